l1_line_arbiter: RTL
====================

// Module: l1_line_arbiter
// PURPOSE
//  Arbitrates cacheline traffic from the split L1 I-cache and D-cache onto the single LLC port of
//  the cacheline adaptor. Sits between the L1 caches and the adaptor. Serves one 256-bit line
//  transaction at a time, end to end, and returns data/resp only to the granted requester.
//  Enables the split-L1 pipeline to share one physical memory path.
// PARAMETERS
//  ADDR_W  32   line address width (byte address, low 5 bits zero)
//  LINE_W  256  cacheline width
//  RR_EN   1    1: round-robin between I and D when both request; 0: fixed D-cache priority
// PORTS
//  clk            in   1       clock; all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  i_pmem_read    in   1       I-cache line read request, held until i_pmem_resp
//  i_pmem_address in   ADDR_W  I-cache line address
//  i_pmem_rdata   out  LINE_W  line to I-cache
//  i_pmem_resp    out  1       1-cycle completion pulse to I-cache
//  d_pmem_read    in   1       D-cache line read (fill), held until d_pmem_resp
//  d_pmem_write   in   1       D-cache line write (writeback), held until d_pmem_resp
//  d_pmem_address in   ADDR_W  D-cache line address
//  d_pmem_wdata   in   LINE_W  D-cache writeback line
//  d_pmem_rdata   out  LINE_W  line to D-cache
//  d_pmem_resp    out  1       1-cycle completion pulse to D-cache
//  llc_read       out  1       read request to adaptor (its read_i)
//  llc_write      out  1       write request to adaptor (its write_i)
//  llc_address    out  ADDR_W  address to adaptor
//  llc_wdata      out  LINE_W  write line to adaptor
//  llc_rdata      in   LINE_W  line from adaptor
//  llc_resp       in   1       adaptor completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=I (next RR tie goes to D); all outputs 0 on the cycle after the
//   reset edge. A reset mid-transaction abandons it with no resp; the adaptor resets on the same edge.
//  States: IDLE, SERVE_I, SERVE_D.
//  IDLE: all llc_* and *_resp outputs are 0. Req_i=i_pmem_read; req_d=d_pmem_read|d_pmem_write.
//   - Neither request -> stay IDLE.
//   - One request -> go to that SERVE state.
//   - Both requests: RR_EN=1 -> grant the side != last_grant; RR_EN=0 -> SERVE_D.
//   - last_grant is updated on every grant.
//  SERVE_x: llc_read/llc_write/llc_address/llc_wdata are driven combinationally from the granted side.
//   - I side: llc_write=0, llc_wdata=0.
//   - llc_rdata is routed to the granted x_pmem_rdata; the other rdata is 0.
//   - x_pmem_resp = llc_resp & (state==SERVE_x). The non-granted resp is never asserted.
//   - On llc_resp -> IDLE. IDLE is a mandatory 1-cycle gap so the requester can drop its request
//     before re-arbitration; no stale re-grant.
//  Latency: request seen in IDLE at cycle t -> llc_* asserted at t+1 -> resp forwarded in the
//   same cycle as llc_resp (0 added cycles on return). Minimum turnaround between transactions: 1 cycle.
//  Requester dropping its request while in SERVE (illegal): stay in SERVE until llc_resp, then
//   discard the response. This is flagged by an assertion.
//  d_pmem_read & d_pmem_write together is illegal and asserted against. If it occurs, write wins.
//  Request arriving during SERVE of the other side: waits, with no loss. It is guaranteed the next
//   grant under RR_EN=1.
//  Grant decision is registered; downstream muxing is combinational from the state register only,
//   with no combinational path from x_pmem_* requests to llc_read/llc_write.
// STRUCTURE
//  Shared package (rv32i_types or cache_pkg): arb_state_t enum {IDLE, SERVE_I, SERVE_D};
//   arb_src_t {SRC_I, SRC_D}; LINE_W and ADDR_W constants.
//  One natural sub-module: l1_arb_pick (combinational) — inputs req_i, req_d, last_grant, RR_EN;
//   outputs grant_valid, grant_src. The FSM, last_grant register and data muxes live in the top.
// TESTING
//  1. I read only: i_pmem_read=1, addr=0x0000_0040, adaptor resp after 8 cycles with line=0xA5..A5
//     -> llc_read=1 from t+1; i_pmem_resp pulse with rdata=0xA5..A5; d_pmem_resp stays 0.
//  2. D writeback: d_pmem_write=1, addr=0x0000_1000, wdata=0xDEAD..BEEF -> llc_write=1 and
//     llc_wdata equals wdata for the whole transaction; llc_read=0; one d_pmem_resp.
//  3. Simultaneous I read 0x100 and D read 0x200 with RR_EN=1 after reset -> D served first,
//     then 1 IDLE cycle, then I served; each requester gets exactly one resp.
//  4. RR_EN=0, D re-requests back-to-back while I waits -> D is always granted; I is served only when
//     D idles. Re-run with RR_EN=1 -> grants alternate D,I,D,I.
//  5. Reset in SERVE_D mid-burst -> next cycle: state IDLE, llc_read=llc_write=0, no resp issued;
//     a fresh I request then completes normally.
//  6. Back-to-back I requests (request reasserted the cycle after resp) -> exactly one IDLE gap
//     cycle, no duplicate grant of the first request.

Source files
------------

// File: rtl/l1_line_arbiter_pkg.sv
// Shared types and widths for the L1 I/D to LLC line arbiter.
package l1_line_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;
endpackage

// File: rtl/l1_line_arbiter_pick.sv
// Combinational grant pick between the I-cache and D-cache line requests.
module l1_arb_pick
    import l1_line_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic     req_i,
    input  logic     req_d,
    input  arb_src_t last_grant,
    output logic     grant_valid,
    output arb_src_t grant_src
);
    always_comb begin
        grant_valid = req_i | req_d;
        grant_src   = SRC_I;
        if (req_i && req_d) begin
            // Tie: alternate away from the previous winner, or favour D (fills/writebacks stall the pipe longer)
            if (RR_EN) grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
            else       grant_src = SRC_D;
        end else if (req_d) begin
            grant_src = SRC_D;
        end
    end
endmodule

// File: rtl/l1_line_arbiter.sv
// Shares the single LLC line port between the L1 I-cache and D-cache, one transaction at a time.
module l1_line_arbiter
    import l1_line_arbiter_pkg::*;
#(
    parameter int ADDR_W = l1_line_arbiter_pkg::ADDR_W,
    parameter int LINE_W = l1_line_arbiter_pkg::LINE_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              llc_read,
    output logic              llc_write,
    output logic [ADDR_W-1:0] llc_address,
    output logic [LINE_W-1:0] llc_wdata,
    input  logic [LINE_W-1:0] llc_rdata,
    input  logic              llc_resp
);
    arb_state_t state_q, state_d;
    arb_src_t   last_grant_q, last_grant_d;
    logic       d_write_q, d_write_d;
    logic       req_i, req_d;
    logic       grant_valid;
    arb_src_t   grant_src;

    assign req_i = i_pmem_read;
    assign req_d = d_pmem_read | d_pmem_write;

    l1_arb_pick #(.RR_EN(RR_EN)) u_pick (
        .req_i       (req_i),
        .req_d       (req_d),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // The D op kind is captured at grant so llc_read/llc_write depend on flops only.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        d_write_d    = d_write_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_src;
                    d_write_d    = d_pmem_write;
                    state_d      = (grant_src == SRC_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (llc_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_I;
            d_write_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            d_write_q    <= d_write_d;
        end
    end

    // A requester that has illegally dropped its request gets its response swallowed.
    always_comb begin
        llc_read     = 1'b0;
        llc_write    = 1'b0;
        llc_address  = '0;
        llc_wdata    = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            SERVE_I: begin
                llc_read     = 1'b1;
                llc_address  = i_pmem_address;
                i_pmem_rdata = llc_rdata;
                i_pmem_resp  = llc_resp & req_i;
            end
            SERVE_D: begin
                llc_read     = ~d_write_q;
                llc_write    = d_write_q;
                llc_address  = d_pmem_address;
                llc_wdata    = d_pmem_wdata;
                d_pmem_rdata = llc_rdata;
                d_pmem_resp  = llc_resp & req_d;
            end
            default: ;
        endcase
    end

    a_i_held: assert property (@(posedge clk) disable iff (rst) (state_q == SERVE_I) |-> req_i);
    a_d_held: assert property (@(posedge clk) disable iff (rst) (state_q == SERVE_D) |-> req_d);
    a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));
endmodule
